// File: rtl/peripheral_wb_noc_host.sv
// Wishbone master that programs the UART line settings after reset, then shuttles
// bytes between a valid/ready stream and the UART THR/RBR registers.
module peripheral_wb_noc_host #(
  parameter logic [15:0] DIVISOR  = 16'h001B,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter int          TX_DEPTH = 8,
  parameter int          TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i,
  output logic       init_done,
  output logic       bus_err
);

  localparam int          AW       = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(TX_DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [3:0] S_INIT0  = 4'd0;
  localparam logic [3:0] S_INIT1  = 4'd1;
  localparam logic [3:0] S_INIT2  = 4'd2;
  localparam logic [3:0] S_INIT3  = 4'd3;
  localparam logic [3:0] S_INIT4  = 4'd4;
  localparam logic [3:0] S_INIT5  = 4'd5;
  localparam logic [3:0] S_IDLE   = 4'd6;
  localparam logic [3:0] S_POLL   = 4'd7;
  localparam logic [3:0] S_RD_RBR = 4'd8;
  localparam logic [3:0] S_WR_THR = 4'd9;

  logic [3:0]    state_reg;
  logic          cyc_reg;
  logic          we_reg;
  logic [2:0]    adr_reg;
  logic [7:0]    dat_reg;
  logic [7:0]    tmo_reg;
  logic [4:0]    burst_reg;
  logic [7:0]    rx_data_reg;
  logic          rx_valid_reg;
  logic          init_done_reg;
  logic          bus_err_reg;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    iss_adr;
  logic [7:0]    iss_dat;
  logic          iss_we;

  assign fifo_empty = (count_reg == '0);
  // Gated by rst so that every output reads 0 while reset is held.
  assign tx_ready   = rst & (count_reg != DEPTH_C);
  assign push       = tx_valid & tx_ready;
  assign pop        = cyc_reg & wb_ack_i & (state_reg == S_WR_THR);
  assign count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign wb_cyc_o  = cyc_reg;
  assign wb_stb_o  = cyc_reg;
  assign wb_we_o   = we_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign wb_sel_o  = {3'b000, cyc_reg};
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign init_done = init_done_reg;
  assign bus_err   = bus_err_reg;

  // A new transaction starts in any bus-idle cycle; the cycle after an ack or
  // abort is always idle, which yields the single gap cycle between transfers.
  always_comb begin
    issue   = 1'b0;
    iss_adr = 3'd0;
    iss_dat = 8'h00;
    iss_we  = 1'b0;
    if (!cyc_reg) begin
      case (state_reg)
        S_INIT0:  begin issue = 1'b1; iss_adr = 3'd3; iss_dat = LCR_VAL | 8'h80; iss_we = 1'b1; end
        S_INIT1:  begin issue = 1'b1; iss_adr = 3'd0; iss_dat = DIVISOR[7:0];    iss_we = 1'b1; end
        S_INIT2:  begin issue = 1'b1; iss_adr = 3'd1; iss_dat = DIVISOR[15:8];   iss_we = 1'b1; end
        S_INIT3:  begin issue = 1'b1; iss_adr = 3'd3; iss_dat = LCR_VAL;         iss_we = 1'b1; end
        S_INIT4:  begin issue = 1'b1; iss_adr = 3'd1; iss_dat = 8'h00;           iss_we = 1'b1; end
        S_INIT5:  begin issue = 1'b1; iss_adr = 3'd2; iss_dat = 8'h07;           iss_we = 1'b1; end
        S_IDLE:   begin issue = ~fifo_empty | ~rx_valid_reg; iss_adr = 3'd5; end
        S_POLL:   begin issue = 1'b1; iss_adr = 3'd5; end
        S_RD_RBR: begin issue = 1'b1; iss_adr = 3'd0; end
        S_WR_THR: begin issue = 1'b1; iss_adr = 3'd0; iss_dat = mem[rd_ptr_reg]; iss_we = 1'b1; end
        default:  issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_INIT0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= 3'd0;
      dat_reg       <= 8'h00;
      tmo_reg       <= 8'h00;
      burst_reg     <= 5'd0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      init_done_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      if (rx_valid_reg && rx_ready) rx_valid_reg <= 1'b0;
      if (issue) begin
        cyc_reg <= 1'b1;
        adr_reg <= iss_adr;
        dat_reg <= iss_dat;
        we_reg  <= iss_we;
        tmo_reg <= 8'h00;
        if (state_reg == S_IDLE) state_reg <= S_POLL;
      end else if (cyc_reg) begin
        if (wb_ack_i) begin
          cyc_reg <= 1'b0;
          we_reg  <= 1'b0;
          case (state_reg)
            S_INIT5: begin
              init_done_reg <= 1'b1;
              state_reg     <= S_IDLE;
            end
            S_POLL: begin
              // Receive wins over transmit when both are possible.
              if (wb_dat_i[0] && !rx_valid_reg) begin
                state_reg <= S_RD_RBR;
              end else if (wb_dat_i[5] && !fifo_empty) begin
                state_reg <= S_WR_THR;
                burst_reg <= 5'd16;
              end else begin
                state_reg <= S_IDLE;
              end
            end
            S_RD_RBR: begin
              rx_data_reg  <= wb_dat_i;
              rx_valid_reg <= 1'b1;
              state_reg    <= S_IDLE;
            end
            S_WR_THR: begin
              burst_reg <= burst_reg - 5'd1;
              if (burst_reg == 5'd1 || count_next == '0) state_reg <= S_IDLE;
            end
            default: state_reg <= state_reg + 4'd1;
          endcase
        end else if (tmo_reg == TMO_LAST) begin
          // Abort; the unchanged state reissues the same transfer after the gap.
          cyc_reg     <= 1'b0;
          we_reg      <= 1'b0;
          bus_err_reg <= 1'b1;
        end else begin
          tmo_reg <= tmo_reg + 8'd1;
        end
      end
    end
  end

endmodule
